// File: rtl/xip_line_cache.sv
// xip_line_cache: direct-mapped AXI-Lite read cache that refills whole lines from the XIP engine.
// Define XIP_LINE_PREFETCH_EN to add a one-line sequential prefetch after each demand fill.
module xip_line_cache #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              xip_en_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [31:0]       rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic              fill_start_o,
  output logic [ADDR_W-1:0] fill_addr_o,
  output logic [31:0]       fill_len_o,
  input  logic [31:0]       fill_data_i,
  input  logic              fill_valid_i,
  input  logic              fill_done_i,
  input  logic              fill_err_i,
  output logic              hit_o,
  output logic              miss_o
);
  localparam int OFF    = $clog2(LINE_WORDS * 4);
  localparam int IDX    = $clog2(NUM_LINES);
  localparam int IDX_W  = (IDX > 0) ? IDX : 1;
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int TAG_W  = ADDR_W - OFF - IDX;
  localparam int CNT_W  = WORD_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef XIP_LINE_PREFETCH_EN
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_FILL, S_RESP, S_PREFETCH} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL, S_RESP} state_t;
`endif

  function automatic logic [IDX_W-1:0] line_idx(input logic [ADDR_W-1:0] a);
    return (IDX > 0) ? IDX_W'(a >> OFF) : '0;
  endfunction

  function automatic logic [TAG_W-1:0] line_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  state_t               state_q, state_d;
  logic                 rdy_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W-1:0]    fill_addr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [31:0]          req_q;
  logic [31:0]          rdata_q;
  logic [1:0]           rresp_q;
  logic                 fill_start_q;
  logic                 hit_q;
  logic                 miss_q;
  logic                 flushed_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES][LINE_WORDS];

  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [WORD_W-1:0] req_word;
  logic              lookup_hit, filling, fill_wr, fill_ok, fill_commit, req_word_now;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              unused_addr_lsb;

  assign req_idx    = line_idx(addr_q);
  assign req_word   = addr_q[OFF-1:2];
  assign fill_idx   = line_idx(fill_addr_q);
  assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == line_tag(addr_q));
  assign unused_addr_lsb = ^addr_q[1:0];

`ifdef XIP_LINE_PREFETCH_EN
  logic              pf_pend_q;
  logic [ADDR_W-1:0] next_line;
  logic              pf_go;
  // Plain add carries into the tag when the index wraps.
  assign next_line = fill_addr_q + ADDR_W'(LINE_WORDS * 4);
  assign pf_go     = pf_pend_q && !arvalid_i && !valid_q[line_idx(next_line)];
  assign filling   = (state_q == S_FILL) || (state_q == S_PREFETCH);
`else
  assign filling   = (state_q == S_FILL);
`endif

  // Words past the end of the line are dropped; the count saturates at LINE_WORDS.
  assign fill_wr      = filling && fill_valid_i && (cnt_q < CNT_FULL);
  assign cnt_nxt      = cnt_q + CNT_W'(fill_wr);
  assign fill_ok      = !fill_err_i && (cnt_nxt == CNT_FULL);
  assign fill_commit  = filling && fill_done_i && fill_ok && !flushed_q && !flush_i;
  assign req_word_now = fill_wr && (cnt_q[WORD_W-1:0] == req_word);

  always_comb begin
    state_d   = state_q;
    arready_o = 1'b0;
    rvalid_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        arready_o = rdy_q;
        if (arvalid_i && rdy_q) state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = (!xip_en_i || lookup_hit) ? S_RESP : S_FILL;
      S_FILL:   if (fill_done_i) state_d = S_RESP;
      S_RESP: begin
        rvalid_o = 1'b1;
`ifdef XIP_LINE_PREFETCH_EN
        if (rready_i) state_d = pf_go ? S_PREFETCH : S_IDLE;
`else
        if (rready_i) state_d = S_IDLE;
`endif
      end
`ifdef XIP_LINE_PREFETCH_EN
      S_PREFETCH: if (fill_done_i) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fill_wr) data_mem[fill_idx][cnt_q[WORD_W-1:0]] <= fill_data_i;
    if (fill_commit) tag_mem[fill_idx] <= line_tag(fill_addr_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rdy_q        <= 1'b0;
      addr_q       <= '0;
      fill_addr_q  <= '0;
      cnt_q        <= '0;
      req_q        <= '0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      fill_start_q <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      flushed_q    <= 1'b0;
      valid_q      <= '0;
`ifdef XIP_LINE_PREFETCH_EN
      pf_pend_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rdy_q        <= 1'b1;
      fill_start_q <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      if (fill_wr) cnt_q <= cnt_nxt;
      if (filling && flush_i) flushed_q <= 1'b1;
      case (state_q)
        S_IDLE: if (arvalid_i && rdy_q) addr_q <= araddr_i;
        S_LOOKUP: begin
          if (!xip_en_i) begin
            rdata_q <= '0;
            rresp_q <= RESP_SLVERR;
          end else if (lookup_hit) begin
            rdata_q <= data_mem[req_idx][req_word];
            rresp_q <= RESP_OKAY;
            hit_q   <= 1'b1;
          end else begin
            fill_start_q <= 1'b1;
            miss_q       <= 1'b1;
            fill_addr_q  <= {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};
            cnt_q        <= '0;
            flushed_q    <= 1'b0;
          end
        end
        S_FILL: begin
          if (req_word_now) req_q <= fill_data_i;
          // A flushed fill still answers the requester; only the valid bit is withheld.
          if (fill_done_i) begin
            rresp_q <= fill_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_q <= !fill_ok ? '0 : (req_word_now ? fill_data_i : req_q);
`ifdef XIP_LINE_PREFETCH_EN
            pf_pend_q <= fill_ok;
`endif
          end
        end
`ifdef XIP_LINE_PREFETCH_EN
        S_RESP: begin
          if (rready_i) begin
            pf_pend_q <= 1'b0;
            if (pf_go) begin
              fill_start_q <= 1'b1;
              fill_addr_q  <= next_line;
              cnt_q        <= '0;
              flushed_q    <= 1'b0;
            end
          end
        end
`endif
        default: ;
      endcase
      if (fill_commit) valid_q[fill_idx] <= 1'b1;
      if (flush_i) valid_q <= '0;
    end
  end

  assign rdata_o      = rdata_q;
  assign rresp_o      = rresp_q;
  assign fill_start_o = fill_start_q;
  assign fill_addr_o  = fill_addr_q;
  assign fill_len_o   = 32'(LINE_WORDS * 4);
  assign hit_o        = hit_q;
  assign miss_o       = miss_q;
endmodule

// File: tb/tb_xip_line_cache.sv
// tb_xip_line_cache: random and directed reads against a line-address reference model
// with a scripted flash fill responder (errors, short/long fills, mid-fill flush, reset).
module tb_xip_line_cache;
  localparam int LW = 4;
  localparam int NL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        xip_en, flush;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic        fill_start;
  logic [31:0] fill_addr, fill_len, fill_data;
  logic        fill_valid, fill_done, fill_err;
  logic        hit, miss;

  xip_line_cache #(.ADDR_W(32), .LINE_WORDS(LW), .NUM_LINES(NL)) dut (
    .clk(clk), .reset(reset), .xip_en_i(xip_en), .flush_i(flush),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
    .fill_start_o(fill_start), .fill_addr_o(fill_addr), .fill_len_o(fill_len),
    .fill_data_i(fill_data), .fill_valid_i(fill_valid), .fill_done_i(fill_done),
    .fill_err_i(fill_err), .hit_o(hit), .miss_o(miss)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int hit_cnt = 0, miss_cnt = 0, fill_cnt = 0;

  always @(posedge clk) begin
    if (hit) hit_cnt++;
    if (miss) miss_cnt++;
    if (fill_start) fill_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Flash image: first 64 bytes erased, the rest a fixed hash of the byte address.
  function automatic logic [31:0] flash(input logic [31:0] a);
    if (a < 32'h40) return 32'hFFFF_FFFF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: which line address each index holds, if any.
  logic [31:0] m_line  [NL];
  bit          m_valid [NL];

  task automatic model_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  // Fill responder knobs.
  bit k_err, k_flush, k_merge;
  int k_words;

  task automatic run_fill(input logic [31:0] line);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    for (int i = 0; i < k_words; i++) begin
      fill_valid = 1'b1;
      fill_data  = flash(line + 32'(4 * i));
      flush      = k_flush && (i == 1);
      if (k_merge && i == k_words - 1) begin
        fill_done = 1'b1;
        fill_err  = k_err;
      end
      @(negedge clk);
    end
    fill_valid = 1'b0;
    flush      = 1'b0;
    if (!(k_merge && k_words > 0)) begin
      fill_done = 1'b1;
      fill_err  = k_err;
      @(negedge clk);
    end
    fill_done = 1'b0;
    fill_err  = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr);
    logic [31:0] line, exp_data;
    logic [1:0]  exp_resp;
    int idx, h0, m0, f0, cyc;
    bit exp_hit, exp_fill, ok, got_rv;
    line     = addr & 32'hFFFF_FFF0;
    idx      = int'((addr >> 4) % NL);
    exp_hit  = xip_en && m_valid[idx] && (m_line[idx] == line);
    exp_fill = xip_en && !exp_hit;
    ok       = !k_err && (k_words >= LW);
    if (!xip_en || (exp_fill && !ok)) begin
      exp_resp = 2'b10;
      exp_data = 32'h0;
    end else begin
      exp_resp = 2'b00;
      exp_data = flash(addr & 32'hFFFF_FFFC);
    end
    h0 = hit_cnt; m0 = miss_cnt; f0 = fill_cnt;
    @(negedge clk);
    check_eq("arready_idle", 32'(arready), 32'd1);
    araddr  = addr;
    arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    cyc     = 1;
    got_rv  = 1'b0;
    while (cyc < 100 && !got_rv) begin
      if (rvalid) begin
        got_rv = 1'b1;
      end else if (fill_start) begin
        check_eq("fill_addr", fill_addr, line);
        check_eq("fill_len", fill_len, 32'd16);
        run_fill(line);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check_eq("rvalid_seen", 32'(got_rv), 32'd1);
    if (!exp_fill) check_eq("no_fill_latency", 32'(cyc), 32'd2);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    check_eq("rvalid_hold", 32'(rvalid), 32'd1);
    check_eq("arready_busy", 32'(arready), 32'd0);
    check_eq("rdata", rdata, exp_data);
    check_eq("rresp", 32'(rresp), 32'(exp_resp));
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check_eq("rvalid_drop", 32'(rvalid), 32'd0);
    check_eq("hit_count", 32'(hit_cnt - h0), 32'(exp_hit));
    check_eq("miss_count", 32'(miss_cnt - m0), 32'(exp_fill));
    check_eq("fill_count", 32'(fill_cnt - f0), 32'(exp_fill));
    if (exp_fill && k_flush) model_clear();
    else if (exp_fill && ok) begin
      m_valid[idx] = 1'b1;
      m_line[idx]  = line;
    end
  endtask

  task automatic knobs_default();
    k_err = 1'b0; k_flush = 1'b0; k_merge = 1'b0; k_words = LW;
  endtask

  initial begin
    int r;
    logic [31:0] a;
    reset = 1'b1; xip_en = 1'b1; flush = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    fill_data = '0; fill_valid = 1'b0; fill_done = 1'b0; fill_err = 1'b0;
    knobs_default();
    model_clear();
    repeat (3) @(negedge clk);
    check_eq("rst_arready", 32'(arready), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_rresp", 32'(rresp), 32'd0);
    check_eq("rst_fill_start", 32'(fill_start), 32'd0);
    check_eq("rst_fill_addr", fill_addr, 32'd0);
    check_eq("rst_fill_len", fill_len, 32'd16);
    check_eq("rst_hit_miss", 32'({hit, miss}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("arready_after_rst", 32'(arready), 32'd1);

    // Directed sequence.
    do_read(32'h0000_0000);
    check_eq("erased_word", rdata, 32'hFFFF_FFFF);
    do_read(32'h0000_0004);
    do_read(32'h0000_0080);
    do_read(32'h0000_0000);
    k_err = 1'b1; do_read(32'h0000_0104);
    k_err = 1'b0; do_read(32'h0000_0104);
    k_flush = 1'b1; do_read(32'h0000_020C);
    k_flush = 1'b0; do_read(32'h0000_0208);
    k_words = 2; do_read(32'h0000_0300);
    k_words = 6; k_merge = 1'b1; do_read(32'h0000_030C);
    knobs_default(); do_read(32'h0000_0300);
    xip_en = 1'b0; do_read(32'h0000_0010); do_read(32'h0000_0300);
    xip_en = 1'b1;

    // Reset in the middle of a fill: everything invalid, late fill inputs ignored.
    @(negedge clk);
    araddr = 32'h0000_0380; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    repeat (20) begin
      if (!fill_start) @(negedge clk);
    end
    check_eq("rstfill_start_seen", 32'(fill_start), 32'd1);
    fill_valid = 1'b1; fill_data = 32'hDEAD_BEEF;
    reset = 1'b1;
    #1;
    check_eq("rstfill_arready", 32'(arready), 32'd0);
    check_eq("rstfill_fill_start", 32'(fill_start), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    fill_done = 1'b1;
    repeat (2) @(negedge clk);
    fill_valid = 1'b0; fill_done = 1'b0;
    check_eq("rstfill_rvalid", 32'(rvalid), 32'd0);
    model_clear();
    do_read(32'h0000_0000);
    do_read(32'h0000_0380);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      r       = int'($urandom_range(0, 99));
      knobs_default();
      k_err   = (r < 10);
      if (r >= 10 && r < 20) k_words = int'($urandom_range(1, 3));
      if (r >= 20 && r < 30) k_words = 6;
      k_flush = (r >= 30 && r < 40);
      k_merge = $urandom_range(0, 1) != 0;
      xip_en  = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
      end
      a = 32'($urandom_range(0, 32'h3FF));
      do_read(a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
